exu_alu_share_arb: RTL and testbench

- Shares one single-cycle ALU datapath between two issue requesters, e.g. pipe i0 and a secondary/replay source.
- The ALU flops its operands on issue and produces its result combinationally one cycle later.
- This block arbitrates round-robin, drives the ALU operand/op bus, tracks the in-flight operation, and buffers results in a small FIFO with valid/ready backpressure and flush.
- It sits between decode/issue and writeback in the EXU.

---
 rtl/exu_alu_share_arb.sv | 115 +++++++++++
 tb/tb_exu_alu_share_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_share_arb.sv
// exu_alu_share_arb: round-robin share of one single-cycle ALU between two requesters, with a result FIFO
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kill in-flight and buffered work
//   req_valid/ready/op/a/b/tag  per-requester issue handshake (index 0 in the low slice)
//   alu_valid/op/a/b          operand bus to the shared ALU, alu_out result one cycle later
//   rsp_valid/ready/src/tag/data  result FIFO head with valid/ready backpressure
module exu_alu_share_arb #(
    parameter int W     = 32,
    parameter int OPW   = 16,
    parameter int TAGW  = 5,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*W-1:0]    req_a,
    input  logic [2*W-1:0]    req_b,
    input  logic [2*TAGW-1:0] req_tag,
    output logic              alu_valid,
    output logic [OPW-1:0]    alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_src,
    output logic [TAGW-1:0]   rsp_tag,
    output logic [W-1:0]      rsp_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, credit;
    logic            rr_ptr, inflight, inflight_src;
    logic [TAGW-1:0] inflight_tag;
    logic [W-1:0]    mem_data [DEPTH];
    logic [TAGW-1:0] mem_tag [DEPTH];
    logic            mem_src [DEPTH];
    logic [W-1:0]    hold_data;
    logic [TAGW-1:0] hold_tag;
    logic            hold_src;
    logic            pop, push, issue_ok, grant, winner;
    logic [TAGW-1:0] win_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rsp_valid = count != '0;
        pop       = rsp_valid & rsp_ready;
        push      = inflight & ~flush;
        // A pop this cycle frees a slot, so it may fund a grant even at zero credit.
        issue_ok  = ~rst & ~flush & ((credit != '0) | pop);
        winner    = (&req_valid) ? rr_ptr : req_valid[1];
        grant     = issue_ok & (|req_valid);
        req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
        alu_valid = grant;
        alu_op    = grant ? (winner ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0]) : '0;
        alu_a     = grant ? (winner ? req_a[2*W-1:W] : req_a[W-1:0]) : '0;
        alu_b     = grant ? (winner ? req_b[2*W-1:W] : req_b[W-1:0]) : '0;
        win_tag   = winner ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
        // An empty FIFO keeps showing the last head that was presented.
        rsp_src   = rsp_valid ? mem_src[rd_ptr]  : hold_src;
        rsp_tag   = rsp_valid ? mem_tag[rd_ptr]  : hold_tag;
        rsp_data  = rsp_valid ? mem_data[rd_ptr] : hold_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credit       <= CW'(DEPTH);
            rr_ptr       <= 1'b0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            inflight_tag <= '0;
            hold_data    <= '0;
            hold_tag     <= '0;
            hold_src     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
                mem_src[i]  <= 1'b0;
            end
        end else begin
            if (grant) begin
                rr_ptr       <= ~winner;
                inflight_src <= winner;
                inflight_tag <= win_tag;
            end
            inflight <= grant;
            if (rsp_valid) begin
                hold_data <= mem_data[rd_ptr];
                hold_tag  <= mem_tag[rd_ptr];
                hold_src  <= mem_src[rd_ptr];
            end
            if (push) begin
                mem_data[wr_ptr] <= alu_out;
                mem_tag[wr_ptr]  <= inflight_tag;
                mem_src[wr_ptr]  <= inflight_src;
            end
            wr_ptr <= flush ? '0 : (push ? ptr_inc(wr_ptr) : wr_ptr);
            rd_ptr <= flush ? '0 : (pop ? ptr_inc(rd_ptr) : rd_ptr);
            count  <= flush ? '0 : count + CW'(push) - CW'(pop);
            credit <= flush ? CW'(DEPTH) : credit - CW'(grant) + CW'(pop);
        end
    end
endmodule

// File: tb/tb_exu_alu_share_arb.sv
// tb_exu_alu_share_arb: directed bench for exu_alu_share_arb with a behavioural ALU and a response scoreboard
module tb_exu_alu_share_arb;
    localparam int W = 32, OPW = 16, TAGW = 5, DEPTH = 2;
    localparam logic [OPW-1:0] OP_ADD = 16'd1, OP_SUB = 16'd2;

    logic              clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [1:0]        req_valid = '0, req_ready;
    logic [2*OPW-1:0]  req_op = '0;
    logic [2*W-1:0]    req_a = '0, req_b = '0;
    logic [2*TAGW-1:0] req_tag = '0;
    logic              alu_valid;
    logic [OPW-1:0]    alu_op;
    logic [W-1:0]      alu_a, alu_b, alu_out;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_src;
    logic [TAGW-1:0]   rsp_tag;
    logic [W-1:0]      rsp_data;

    exu_alu_share_arb #(.W(W), .OPW(OPW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_rsp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (op == OP_ADD) ? a + b : (op == OP_SUB) ? a - b : a ^ b;
    endfunction

    // Behavioural ALU: operands flopped on issue, result combinational next cycle.
    logic [OPW-1:0] op_q;
    logic [W-1:0]   a_q, b_q;
    assign alu_out = alu_f(op_q, a_q, b_q);

    typedef struct {
        logic            src;
        logic [TAGW-1:0] tag;
        logic [W-1:0]    data;
    } ent_t;
    ent_t q[$];
    logic gq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            gq.delete();
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            ent_t e;
            logic w;
            check("credit", 64'(dut.credit), 64'(DEPTH - q.size()));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) check("rsp_extra", 1, 0);
                else begin
                    e = q.pop_front();
                    check("rsp_src", rsp_src, e.src);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_data", rsp_data, e.data);
                    n_rsp++;
                end
            end
            if (flush) q.delete();
            if (|(req_valid & req_ready)) begin
                w = req_ready[1];
                e.src  = w;
                e.tag  = w ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
                e.data = w ? alu_f(req_op[2*OPW-1:OPW], req_a[2*W-1:W], req_b[2*W-1:W])
                           : alu_f(req_op[OPW-1:0], req_a[W-1:0], req_b[W-1:0]);
                q.push_back(e);
                gq.push_back(w);
            end
            if (alu_valid) begin
                op_q <= alu_op;
                a_q  <= alu_a;
                b_q  <= alu_b;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TAGW-1:0] tag);
        if (i == 0) begin
            req_op[OPW-1:0] = op; req_a[W-1:0] = a; req_b[W-1:0] = b; req_tag[TAGW-1:0] = tag;
        end else begin
            req_op[2*OPW-1:OPW] = op; req_a[2*W-1:W] = a; req_b[2*W-1:W] = b; req_tag[2*TAGW-1:TAGW] = tag;
        end
    endtask

    task automatic drain;
        req_valid = 2'b00;
        flush = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) cyc;
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int grants, sent, base;
        repeat (2) cyc;
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_credit", dut.credit, 2);

        // Single requester: 5+7 tag 3
        cyc;
        set_req(0, OP_ADD, 5, 7, 3);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        check("single_ready", req_ready, 2'b01);
        check("single_alu_valid", alu_valid, 1);
        check("single_alu_a", alu_a, 5);
        check("single_alu_b", alu_b, 7);
        cyc;
        req_valid = 2'b00;
        #1;
        check("single_c1_valid", rsp_valid, 0);
        cyc;
        #1;
        check("single_c2_valid", rsp_valid, 1);
        check("single_c2_data", rsp_data, 12);
        check("single_c2_tag", rsp_tag, 3);
        check("single_c2_src", rsp_src, 0);
        cyc;
        #1;
        check("hold_valid", rsp_valid, 0);
        check("hold_data", rsp_data, 12);
        check("hold_tag", rsp_tag, 3);
        drain;

        // Contention: rr_ptr is 1 after the single grant to req0
        gq.delete();
        for (int k = 0; k < 4; k++) begin
            cyc;
            set_req(0, OP_ADD, 32'(10 + k), 1, 5'(k));
            set_req(1, OP_SUB, 32'(50 + k), 2, 5'(16 + k));
            req_valid = 2'b11;
        end
        cyc;
        req_valid = 2'b00;
        check("cont_grants", gq.size(), 4);
        if (gq.size() == 4) begin
            check("cont_g0", gq[0], 1);
            check("cont_g1", gq[1], 0);
            check("cont_g2", gq[2], 1);
            check("cont_g3", gq[3], 0);
        end
        drain;

        // Backpressure: only DEPTH grants while the consumer stalls
        rsp_ready = 1'b0;
        grants = 0;
        for (int k = 0; k < 5; k++) begin
            cyc;
            set_req(0, OP_ADD, 32'(100 + k), 1, 5'(20 + k));
            req_valid = 2'b01;
            #1;
            if (req_ready[0]) grants++;
        end
        check("bp_grants", grants, DEPTH);
        check("bp_stalled", req_ready, 2'b00);
        cyc;
        rsp_ready = 1'b1;
        #1;
        check("bp_pop_grant", req_ready, 2'b01);
        cyc;
        rsp_ready = 1'b0;
        #1;
        check("bp_after", req_ready, 2'b00);

        // Flush with two buffered results
        cyc;
        flush = 1'b1;
        #1;
        check("fl1_ready", req_ready, 2'b00);
        check("fl1_alu_valid", alu_valid, 0);
        cyc;
        flush = 1'b0;
        #1;
        check("fl1_rsp_valid", rsp_valid, 0);
        check("fl1_credit", dut.credit, 2);
        check("fl1_regrant", req_ready, 2'b01);
        // Second flush with one buffered and one in flight
        cyc;
        #1;
        check("fl2_g2", req_ready, 2'b01);
        cyc;
        flush = 1'b1;
        #1;
        check("fl2_inflight", dut.inflight, 1);
        check("fl2_ready", req_ready, 2'b00);
        check("fl2_alu_valid", alu_valid, 0);
        cyc;
        flush = 1'b0;
        set_req(0, OP_ADD, 40, 2, 9);
        #1;
        check("fl2_rsp_valid", rsp_valid, 0);
        check("fl2_credit", dut.credit, 2);
        check("fl2_regrant", req_ready, 2'b01);
        drain;

        // Asynchronous reset with FIFO non-empty
        rsp_ready = 1'b0;
        cyc;
        set_req(1, OP_ADD, 30, 3, 7);
        req_valid = 2'b10;
        cyc;
        req_valid = 2'b11;
        cyc;
        #1;
        check("ar_pre_valid", rsp_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_rsp_valid", rsp_valid, 0);
        check("ar_rsp_data", rsp_data, 0);
        check("ar_rsp_tag", rsp_tag, 0);
        check("ar_rsp_src", rsp_src, 0);
        check("ar_req_ready", req_ready, 0);
        check("ar_alu_valid", alu_valid, 0);
        cyc;
        rst = 1'b0;
        set_req(0, OP_ADD, 1, 1, 1);
        set_req(1, OP_ADD, 2, 2, 2);
        req_valid = 2'b11;
        #1;
        check("ar_first_grant", req_ready, 2'b01);
        drain;

        // Wrap-around: ten requests from req1, consumer toggling
        base = n_rsp;
        sent = 0;
        for (int c = 0; c < 100 && sent < 10; c++) begin
            cyc;
            set_req(1, OP_SUB, 32'(sent * 3 + 1), 1, 5'(sent));
            req_valid = 2'b10;
            rsp_ready = (c % 2) == 0;
            #1;
            if (req_ready[1]) sent++;
        end
        cyc;
        req_valid = 2'b00;
        drain;
        check("wrap_sent", sent, 10);
        check("wrap_rcvd", n_rsp - base, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
